// File: rtl/ps2_key_decoder.sv
// PS/2 receiver and set-2 scan-code decoder producing held-key levels for two players.
// Optional define PS2_PARITY_CHECK_EN enables odd-parity checking of received frames.
`timescale 1ns/1ps
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       p1_right,
    output logic       p1_left,
    output logic       p1_jump,
    output logic       p1_squat,
    output logic       p1_defend,
    output logic       p2_right,
    output logic       p2_left,
    output logic       p2_jump,
    output logic       p2_squat,
    output logic       p2_defend,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_clk_d;
    logic          r_dat_s1, r_dat_s2;
    logic          r_fall, r_bit;
    state_t        r_state, w_state_nxt;
    logic [2:0]    r_cnt;
    logic [7:0]    r_shift;
    logic [TW-1:0] r_tmr;
    logic          r_ext, r_brk;
    logic [9:0]    r_keys;
    logic [7:0]    r_code;
    logic          r_code_valid, r_frame_err;
    logic          w_timeout, w_accept, w_drop, w_par_ok;
    logic [9:0]    w_key_sel;

    // Pin synchronizers; the falling edge and its data bit are registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_d  <= 1'b0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
            r_fall   <= 1'b0;
            r_bit    <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= r_clk_d & ~r_clk_s2;
            r_bit    <= r_dat_s2;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;
    always_ff @(posedge clk) begin
        if (rst)                               r_par <= 1'b0;
        else if (r_state == S_PARITY && r_fall) r_par <= r_bit;
    end
    assign w_par_ok = ^{r_shift, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_timeout = (r_state != S_IDLE) && (r_tmr == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE:   if (r_fall && !r_bit) w_state_nxt = S_DATA;
            S_DATA:   if (r_fall && r_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (r_fall) w_state_nxt = S_STOP;
            S_STOP: begin
                if (r_fall) begin
                    w_state_nxt = S_IDLE;
                    if (r_bit && w_par_ok) w_accept = 1'b1;
                    else                   w_drop   = 1'b1;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        // A stalled frame is abandoned regardless of any coincident edge
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_drop      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 3'd0;
            r_shift <= 8'd0;
            r_tmr   <= '0;
        end else begin
            if (r_state == S_IDLE)          r_cnt <= 3'd0;
            else if (r_state == S_DATA && r_fall) begin
                r_cnt   <= r_cnt + 3'd1;
                r_shift <= {r_bit, r_shift[7:1]};
            end
            if (w_state_nxt == S_IDLE || r_state == S_IDLE || r_fall) r_tmr <= '0;
            else if (r_tmr != TW'(TIMEOUT_CYC))                         r_tmr <= r_tmr + TW'(1);
        end
    end

    // Scan-code map: index = {p2 defend,squat,jump,left,right, p1 defend,squat,jump,left,right}
    always_comb begin
        w_key_sel = '0;
        case ({r_ext, r_shift})
            9'h023:  w_key_sel[0] = 1'b1;
            9'h01C:  w_key_sel[1] = 1'b1;
            9'h01D:  w_key_sel[2] = 1'b1;
            9'h01B:  w_key_sel[3] = 1'b1;
            9'h02B:  w_key_sel[4] = 1'b1;
            9'h174:  w_key_sel[5] = 1'b1;
            9'h16B:  w_key_sel[6] = 1'b1;
            9'h175:  w_key_sel[7] = 1'b1;
            9'h172:  w_key_sel[8] = 1'b1;
            9'h05A:  w_key_sel[9] = 1'b1;
            default: w_key_sel    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_keys       <= '0;
            r_code       <= 8'd0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_accept) begin
                r_code       <= r_shift;
                r_code_valid <= 1'b1;
                if (r_shift == 8'hE0)      r_ext <= 1'b1;
                else if (r_shift == 8'hF0) r_brk <= 1'b1;
                else begin
                    r_keys <= r_brk ? (r_keys & ~w_key_sel) : (r_keys | w_key_sel);
                    r_ext  <= 1'b0;
                    r_brk  <= 1'b0;
                end
            end else if (w_drop) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end
        end
    end

    assign {p2_defend, p2_squat, p2_jump, p2_left, p2_right} = r_keys[9:5];
    assign {p1_defend, p1_squat, p1_jump, p1_left, p1_right} = r_keys[4:0];
    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of frames with expected key levels plus
// hand sequences for reset, mid-frame reset and timeout.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
    localparam int unsigned TO   = 60;
    localparam int          HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic p1_right, p1_left, p1_jump, p1_squat, p1_defend;
    logic p2_right, p2_left, p2_jump, p2_squat, p2_defend;
    logic [7:0] code;
    logic code_valid, frame_err;
    logic [9:0] keys;

    int total = 0;
    int bad   = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;

    ps2_key_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .p1_right(p1_right), .p1_left(p1_left), .p1_jump(p1_jump),
        .p1_squat(p1_squat), .p1_defend(p1_defend),
        .p2_right(p2_right), .p2_left(p2_left), .p2_jump(p2_jump),
        .p2_squat(p2_squat), .p2_defend(p2_defend),
        .code(code), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign keys = {p2_defend, p2_squat, p2_jump, p2_left, p2_right,
                   p1_defend, p1_squat, p1_jump, p1_left, p1_right};

    always @(negedge clk) begin
        if (code_valid) cv_cnt <= cv_cnt + 1;
        if (frame_err)  fe_cnt <= fe_cnt + 1;
    end

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         stop;
        logic [9:0] keys;
        logic [7:0] code;
        int         cv;
        int         fe;
    } vec_t;

    vec_t tv[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        bit pc;
        logic [9:0] pr;
        int cv0, fe0;
`ifdef PS2_PARITY_CHECK_EN
        pc = 1'b1;
`else
        pc = 1'b0;
`endif
        pr = pc ? 10'h000 : 10'h001;

        tv[0]  = '{8'h1D, 1'b0, 1'b1, 10'h004, 8'h1D, 1, 0};
        tv[1]  = '{8'hF0, 1'b0, 1'b1, 10'h004, 8'hF0, 1, 0};
        tv[2]  = '{8'h1D, 1'b0, 1'b1, 10'h000, 8'h1D, 1, 0};
        tv[3]  = '{8'hE0, 1'b0, 1'b1, 10'h000, 8'hE0, 1, 0};
        tv[4]  = '{8'h74, 1'b0, 1'b1, 10'h020, 8'h74, 1, 0};
        tv[5]  = '{8'hE0, 1'b0, 1'b1, 10'h020, 8'hE0, 1, 0};
        tv[6]  = '{8'hF0, 1'b0, 1'b1, 10'h020, 8'hF0, 1, 0};
        tv[7]  = '{8'h74, 1'b0, 1'b1, 10'h000, 8'h74, 1, 0};
        tv[8]  = '{8'hE0, 1'b0, 1'b1, 10'h000, 8'hE0, 1, 0};
        tv[9]  = '{8'h1C, 1'b0, 1'b1, 10'h000, 8'h1C, 1, 0};
        tv[10] = '{8'h1C, 1'b0, 1'b1, 10'h002, 8'h1C, 1, 0};
        tv[11] = '{8'h23, 1'b1, 1'b1, 10'h002 | pr, pc ? 8'h1C : 8'h23, pc ? 0 : 1, pc ? 1 : 0};
        tv[12] = '{8'hF0, 1'b0, 1'b1, 10'h002 | pr, 8'hF0, 1, 0};
        tv[13] = '{8'hE0, 1'b0, 1'b0, 10'h002 | pr, 8'hF0, 0, 1};
        tv[14] = '{8'h1C, 1'b0, 1'b1, 10'h002 | pr, 8'h1C, 1, 0};
        tv[15] = '{8'h1B, 1'b0, 1'b1, 10'h00A | pr, 8'h1B, 1, 0};
        tv[16] = '{8'h1B, 1'b0, 1'b1, 10'h00A | pr, 8'h1B, 1, 0};
        tv[17] = '{8'hAA, 1'b0, 1'b1, 10'h00A | pr, 8'hAA, 1, 0};
        tv[18] = '{8'h5A, 1'b0, 1'b1, 10'h20A | pr, 8'h5A, 1, 0};
        tv[19] = '{8'h2B, 1'b0, 1'b1, 10'h21A | pr, 8'h2B, 1, 0};

        // Reset state
        rst = 1'b1;
        wait_clk(3);
        check("reset keys", 32'(keys), 32'h0);
        check("reset code", 32'(code), 32'h0);
        check("reset code_valid", 32'(code_valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        wait_clk(5);

        for (int i = 0; i < 20; i++) begin
            cv0 = cv_cnt;
            fe0 = fe_cnt;
            ps2_bits(mk_frame(tv[i].b, tv[i].bad_par, tv[i].stop), 11);
            wait_clk(2 * HALF);
            check($sformatf("v%0d keys", i), 32'(keys), 32'(tv[i].keys));
            check($sformatf("v%0d code", i), 32'(code), 32'(tv[i].code));
            check($sformatf("v%0d code_valid count", i), 32'(cv_cnt - cv0), 32'(tv[i].cv));
            check($sformatf("v%0d frame_err count", i), 32'(fe_cnt - fe0), 32'(tv[i].fe));
        end

        // Reset in the middle of a frame clears everything on the next cycle
        ps2_bits(mk_frame(8'h55, 1'b0, 1'b1), 4);
        rst = 1'b1;
        wait_clk(1);
        check("midrst keys", 32'(keys), 32'h0);
        check("midrst code", 32'(code), 32'h0);
        check("midrst code_valid", 32'(code_valid), 32'h0);
        check("midrst frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        wait_clk(30);
        ps2_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11);
        wait_clk(2 * HALF);
        check("post-rst 5A keys", 32'(keys), 32'h200);
        check("post-rst 5A code", 32'(code), 32'h5A);

        // Stalled frame: abandoned after the timeout with exactly one error pulse
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        ps2_bits(mk_frame(8'h2B, 1'b0, 1'b1), 5);
        wait_clk(int'(TO) + 40);
        check("timeout frame_err count", 32'(fe_cnt - fe0), 32'd1);
        check("timeout code_valid count", 32'(cv_cnt - cv0), 32'd0);
        check("timeout keys", 32'(keys), 32'h200);
        ps2_bits(mk_frame(8'h2B, 1'b0, 1'b1), 11);
        wait_clk(2 * HALF);
        check("after timeout keys", 32'(keys), 32'h210);
        check("after timeout code", 32'(code), 32'h2B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

PS/2 keyboard receiver and scan-code decoder that drives the per-player command inputs of the game-control layer. It samples the raw `ps2_clk`/`ps2_data` pins, assembles 11-bit device-to-host frames and tracks set-2 make/break/extended codes. It outputs one held-key level per player action (right, left, jump, squat, defend) for two players, which feed the player-state modules directly.

## Interface
- `TIMEOUT_CYC`, default 50000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `p1_right`, `p1_left`, `p1_jump`, `p1_squat`, `p1_defend`  out  1 each  player-1 key held.
- `p2_right`, `p2_left`, `p2_jump`, `p2_squat`, `p2_defend`  out  1 each  player-2 key held.
- `code`  out  8  last accepted byte.
- `code_valid`  out  1  one-cycle pulse when `code` updates.
- `frame_err`  out  1  one-cycle pulse on a dropped frame.

## Operation
- Both pins pass through 2-FF synchronizers. A falling edge is registered when the synced clock goes from 1 to 0 between consecutive cycles. All bit sampling takes synced `ps2_data` in the cycle the edge is detected.
- Frame FSM:
  - IDLE: an edge with data=0 goes to DATA, bit count 0. An edge with data=1 is ignored.
  - DATA: 8 edges shift data in LSB first, then go to PARITY.
  - PARITY: 1 edge captures the parity bit, then go to STOP.
  - STOP: 1 edge. If data=1 and the frame is otherwise good, the byte is accepted. In every case, return to IDLE.
- Timeout: in DATA, PARITY or STOP, a counter runs and is cleared on every edge. When it reaches `TIMEOUT_CYC`, the FSM returns to IDLE, `frame_err` pulses and the partial byte is discarded.
- Stop bit 0: `frame_err` pulses and the byte is dropped.
- Decoder state: prefix flags `ext` and `brk`, both cleared at reset.
- Handling of each accepted byte B:
  - B=0xE0: set `ext`.
  - B=0xF0: set `brk`.
  - Any other B: look up (`ext`, B). A mapped key is set to `!brk`. Unmapped codes, including 0xE1, 0xAA and 0xFA, are ignored. Then clear `ext` and `brk`.
- On a dropped frame, `ext` and `brk` are cleared. Key levels are unchanged.
- Map, player 1 (non-extended):
  - D 0x23 → right
  - A 0x1C → left
  - W 0x1D → jump
  - S 0x1B → squat
  - F 0x2B → defend
- Map, player 2:
  - E0 74 → right
  - E0 6B → left
  - E0 75 → jump
  - E0 72 → squat
  - 0x5A (Enter, non-extended) → defend
- A non-extended code never matches an extended entry, and an extended code never matches a non-extended entry. For example, E0 1C is unmapped.
- Typematic repeats of a make code are harmless: the level stays 1.
- Opposing keys, such as right and left together, are both reported. Priority is resolved downstream.

## Timing
- Reset: all key outputs 0, `code`=0x00, `code_valid`=0, `frame_err`=0, FSM in IDLE, counters 0, `ext`=`brk`=0.
- Reset asserted mid-frame discards the frame. The first valid edge after reset must be a start bit.
- Pin-to-edge latency is 3 cycles: 2 synchronizer stages plus the edge register.
- `code`, `code_valid` and the key levels are registered. They update in the cycle after the stop-bit edge is detected, all in the same cycle.
- `frame_err` asserts in the cycle after the bad stop edge, or after the cycle the timeout count is reached.
- The timeout counter saturates at `TIMEOUT_CYC`. It is held at 0 in IDLE.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the received parity bit must make the 9 bits (data plus parity) odd. On mismatch, `frame_err` pulses at STOP, the byte is dropped and the prefix flags are cleared.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is clocked in and ignored. Only the stop bit and the timeout can drop a frame.

## Test plan
- Reset, then send 0x1D, then F0 1D: `p1_jump` is 0→1→0. `code_valid` pulses 3 times with `code` = 1D, F0, 1D.
- Send E0 74, then E0 F0 74: `p2_right` is 1 then 0, and `p1_right` stays 0 throughout.
- Send E0 1C: no output changes, and `ext` clears, so a following 1C sets `p1_left`=1.
- With `PS2_PARITY_CHECK_EN`, send 0x23 with even parity: `frame_err` pulses, `p1_right` stays 0. Without the macro, `p1_right`=1.
- Stop after 4 data bits and idle `TIMEOUT_CYC` cycles: `frame_err` pulses once. A following full 0x2B frame sets `p1_defend`=1.
- Hold `p1_squat` and `p2_defend`, then pulse `rst` mid-frame: all outputs are 0 the next cycle. A subsequent 0x5A frame sets only `p2_defend`.
